// File: rtl/eei_wb_seq_if.sv
// Bundles the EEI result handshake and register-file write port of the write-back sequencer.
// master: execution-unit/core side; slave: the sequencer.
interface eei_wb_seq_if #(
    parameter int unsigned RD_MAX = 4
) ();
    logic                   wb_req_i;
    logic                   wb_error_i;
    logic [1:0]             wb_rd_op_i;
    logic [4:0]             wb_rd_idx_i;
    logic [4:0]             wb_batch_start_i;
    logic [4:0]             wb_rd_len_i;
    logic [RD_MAX-1:0][31:0] wb_rd_val_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;
    logic                   rf_we_o;
    logic [4:0]             rf_waddr_o;
    logic [31:0]            rf_wdata_o;

    modport master (
        output wb_req_i, wb_error_i, wb_rd_op_i, wb_rd_idx_i, wb_batch_start_i, wb_rd_len_i,
               wb_rd_val_i,
        input  busy_o, done_o, err_o, rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport slave (
        input  wb_req_i, wb_error_i, wb_rd_op_i, wb_rd_idx_i, wb_batch_start_i, wb_rd_len_i,
               wb_rd_val_i,
        output busy_o, done_o, err_o, rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/eei_wb_seq.sv
// EEI write-back sequencer: buffers single/batch rd results and drains them one per cycle.
// Define SOPHON_EEI_WB_FWD_EN to forward error-free single-rd results combinationally.
module eei_wb_seq #(
    parameter int unsigned RD_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    eei_wb_seq_if.slave bus
);
    localparam int unsigned IdxW   = (RD_MAX > 1) ? $clog2(RD_MAX) : 1;
    localparam logic [5:0]  RdMax6 = 6'(RD_MAX);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [RD_MAX-1:0][31:0] buf_q, buf_d;
    logic [4:0]              base_q, base_d, n_q, n_d, slot_q, slot_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;
    logic [4:0]              waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;

    logic       last_slot, can_accept, accept, dropped, len_ovf, req_bad, req_writes;
    logic [4:0] req_n, slot_addr;
    logic       fwd, fwd_we;
    logic [4:0] fwd_waddr;
    logic [31:0] fwd_wdata;

    // The final drain cycle also accepts a new request, giving back-to-back throughput.
    assign last_slot  = (state_q == StDrain) && (slot_q == n_q - 5'd1);
    assign can_accept = (state_q == StIdle) || last_slot;
    assign accept     = bus.wb_req_i && can_accept;
    assign dropped    = bus.wb_req_i && !can_accept;
    assign len_ovf    = {1'b0, bus.wb_rd_len_i} > RdMax6;
    assign req_bad    = bus.wb_error_i || (bus.wb_rd_op_i == 2'd3);

    always_comb begin
        req_n = 5'd0;
        if (!bus.wb_error_i) begin
            unique case (bus.wb_rd_op_i)
                2'd1:    req_n = 5'd1;
                2'd2:    req_n = len_ovf ? RdMax6[4:0] : bus.wb_rd_len_i;
                default: req_n = 5'd0;
            endcase
        end
    end

`ifdef SOPHON_EEI_WB_FWD_EN
    // Forwarding only from a true idle state so it never collides with a drain write.
    assign fwd       = accept && (state_q == StIdle) && (bus.wb_rd_op_i == 2'd1) &&
                       !bus.wb_error_i;
    assign fwd_we    = fwd && (bus.wb_rd_idx_i != 5'd0);
    assign fwd_waddr = fwd_we ? bus.wb_rd_idx_i : 5'd0;
    assign fwd_wdata = fwd_we ? bus.wb_rd_val_i[0] : 32'd0;
`else
    assign fwd       = 1'b0;
    assign fwd_we    = 1'b0;
    assign fwd_waddr = 5'd0;
    assign fwd_wdata = 32'd0;
`endif

    assign req_writes = accept && (req_n != 5'd0) && !fwd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            buf_q   <= '0;
            base_q  <= 5'd0;
            n_q     <= 5'd0;
            slot_q  <= 5'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            base_q  <= base_d;
            n_q     <= n_d;
            slot_q  <= slot_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        base_d  = base_q;
        n_d     = n_q;
        slot_d  = slot_q;
        ovf_d   = ovf_q;
        if (req_writes) begin
            state_d = StDrain;
            buf_d   = bus.wb_rd_val_i;
            base_d  = (bus.wb_rd_op_i == 2'd1) ? bus.wb_rd_idx_i : bus.wb_batch_start_i;
            n_d     = req_n;
            slot_d  = 5'd0;
            ovf_d   = (bus.wb_rd_op_i == 2'd2) && len_ovf;
        end else if (last_slot) begin
            state_d = StIdle;
        end else if (state_q == StDrain) begin
            slot_d = slot_q + 5'd1;
        end
    end

    // Next values of the registered outputs, derived from the slot issued next cycle.
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        we_d      = 1'b0;
        waddr_d   = 5'd0;
        wdata_d   = 32'd0;
        slot_addr = base_d + slot_d;
        if (state_d == StDrain) begin
            busy_d = 1'b1;
            we_d   = (slot_addr != 5'd0);
            if (we_d) begin
                waddr_d = slot_addr;
                wdata_d = buf_d[slot_d[IdxW-1:0]];
            end
            done_d = (slot_d == n_d - 5'd1);
            err_d  = done_d && ovf_d;
        end else if (accept && !fwd) begin
            done_d = 1'b1;
            err_d  = req_bad;
        end
        err_d = err_d || dropped;
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q || fwd;
    assign bus.err_o      = err_q;
    assign bus.rf_we_o    = we_q || fwd_we;
    assign bus.rf_waddr_o = waddr_q | fwd_waddr;
    assign bus.rf_wdata_o = wdata_q | fwd_wdata;
endmodule
